// File: rtl/booth_mac_pkg.sv
// booth_mac_pkg: burst state encoding and signed-add overflow detect shared by the MAC stage
package booth_mac_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  function automatic logic add_ovf(input logic a_s, input logic b_s, input logic s_s);
    return (a_s == b_s) && (s_s != a_s);
  endfunction
endpackage

// File: rtl/booth_mac_add.sv
// booth_mac_add: signed acc_size add with overflow flag, clamping on overflow when BOOTH_MAC_SAT_EN is defined
module booth_mac_add
  import booth_mac_pkg::*;
#(
  parameter int acc_size = 16
) (
  input  logic [acc_size-1:0] a,
  input  logic [acc_size-1:0] b,
  output logic [acc_size-1:0] sum,
  output logic                ovf
);
  logic [acc_size-1:0] raw;
  always_comb begin
    raw = a + b;
    ovf = add_ovf(a[acc_size-1], b[acc_size-1], raw[acc_size-1]);
`ifdef BOOTH_MAC_SAT_EN
    sum = ovf ? {a[acc_size-1], {(acc_size-1){~a[acc_size-1]}}} : raw;
`else
    sum = raw;
`endif
  end
endmodule

// File: rtl/booth_mac_accum.sv
// booth_mac_accum: burst multiply-accumulate of signed products with valid/ready result, saturating under BOOTH_MAC_SAT_EN
module booth_mac_accum
  import booth_mac_pkg::*;
#(
  parameter int m_size    = 4,
  parameter int r_size    = 4,
  parameter int res_size  = m_size + r_size,
  parameter int acc_size  = 16,
  parameter int max_beats = 8,
  parameter int cnt_size  = $clog2(max_beats + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [res_size-1:0] prod,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [acc_size-1:0] acc_out,
  output logic [cnt_size-1:0] beat_cnt,
  output logic                ovf
);
  state_t              state_q, state_d;
  logic [acc_size-1:0] acc_q, acc_d, acc_out_q, acc_out_d, prod_x, sum;
  logic [cnt_size-1:0] cnt_q, cnt_d, beat_cnt_q, beat_cnt_d, cnt_inc;
  logic                ovf_acc_q, ovf_acc_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic                add_ovf_w, ovf_new, accept, close;
  assign prod_x = acc_size'($signed(prod));
  booth_mac_add #(.acc_size(acc_size)) u_add (
    .a   (acc_q),
    .b   (prod_x),
    .sum (sum),
    .ovf (add_ovf_w)
  );
  always_comb begin
    accept      = in_valid && state_q == ACCUM;
    cnt_inc     = cnt_q + 1'b1;
    ovf_new     = ovf_acc_q | add_ovf_w;
    close       = accept && (in_last || cnt_inc == cnt_size'(max_beats));
    acc_d       = close ? '0 : accept ? sum : acc_q;
    cnt_d       = close ? '0 : accept ? cnt_inc : cnt_q;
    ovf_acc_d   = close ? 1'b0 : accept ? ovf_new : ovf_acc_q;
    acc_out_d   = close ? sum : acc_out_q;
    beat_cnt_d  = close ? cnt_inc : beat_cnt_q;
    ovf_d       = close ? ovf_new : ovf_q;
    out_valid_d = close | (out_valid_q & ~out_ready);
    state_d     = close ? HOLD : (state_q == HOLD && out_ready) ? ACCUM : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      acc_out_q   <= '0;
      beat_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      acc_out_q   <= acc_out_d;
      beat_cnt_q  <= beat_cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready  = state_q == ACCUM;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign beat_cnt  = beat_cnt_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_booth_mac_accum.sv
// tb_booth_mac_accum: randomized and directed bursts on 16-bit and 8-bit accumulator instances against an arithmetic model
module tb_booth_mac_accum;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic [7:0] prod;
  logic in_ready, out_valid, ovf, n_in_ready, n_out_valid, n_ovf;
  logic [15:0] acc_out;
  logic [7:0] n_acc_out;
  logic [3:0] beat_cnt, n_beat_cnt;
  int total = 0;
  int passed = 0;
  int ps[8];
  int n;
  always #5 clk = ~clk;
  booth_mac_accum u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .beat_cnt(beat_cnt), .ovf(ovf)
  );
  booth_mac_accum #(.acc_size(8)) u_nar (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .prod(prod),
    .in_last(in_last), .out_valid(n_out_valid), .out_ready(out_ready),
    .acc_out(n_acc_out), .beat_cnt(n_beat_cnt), .ovf(n_ovf)
  );
  function automatic void model(input int w, output int sum, output bit ov);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    int s;
    sum = 0;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = sum + ps[i];
      if (s > hi || s < lo) begin
        ov = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
        s = (s > hi) ? hi : lo;
`else
        s = (s > hi) ? s - (1 << w) : s + (1 << w);
`endif
      end
      sum = s;
    end
  endfunction
  task automatic drive_burst(input bit use_last);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
      total++;
      if (in_ready !== 1'b1) $display("FAIL drive_ready in_ready=%0b expected 1", in_ready);
      else passed++;
      in_valid = 1'b1;
      prod = ps[i][7:0];
      in_last = use_last && i == n - 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic fill_random(input int len);
    n = len;
    for (int i = 0; i < 8; i++) ps[i] = int'($urandom_range(255, 0)) - 128;
  endtask
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; prod = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, ovf, beat_cnt, acc_out} !== {1'b1, 1'b0, 1'b0, 4'd0, 16'd0})
      $display("FAIL reset got rdy=%0b v=%0b ovf=%0b cnt=%0d acc=%0h expected 1 0 0 0 0", in_ready, out_valid, ovf, beat_cnt, acc_out);
    else passed++;
    total++;
    if ({n_in_ready, n_out_valid, n_ovf, n_beat_cnt, n_acc_out} !== {1'b1, 1'b0, 1'b0, 4'd0, 8'd0})
      $display("FAIL reset_narrow got rdy=%0b v=%0b ovf=%0b cnt=%0d acc=%0h expected 1 0 0 0 0", n_in_ready, n_out_valid, n_ovf, n_beat_cnt, n_acc_out);
    else passed++;
  endtask
  task automatic test_basic;
    int es, ns;
    bit eo, no;
    n = 3; ps[0] = 6; ps[1] = -3; ps[2] = 10;
    drive_burst(1'b1);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 16'd13 || beat_cnt !== 4'd3 || ovf !== 1'b0)
      $display("FAIL basic got v=%0b acc=%0d cnt=%0d ovf=%0b expected v=1 acc=13 cnt=3 ovf=0", out_valid, $signed(acc_out), beat_cnt, ovf);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL basic_one_cycle out_valid=%0b expected 0", out_valid);
    else passed++;
    repeat (6) begin
      fill_random(int'($urandom_range(7, 1)));
      drive_burst(1'b1);
      model(16, es, eo);
      model(8, ns, no);
      total++;
      if (out_valid !== 1'b1 || acc_out !== 16'(es) || beat_cnt !== 4'(n) || ovf !== eo)
        $display("FAIL rand_wide got v=%0b acc=%0d cnt=%0d ovf=%0b expected v=1 acc=%0d cnt=%0d ovf=%0b", out_valid, $signed(acc_out), beat_cnt, ovf, es, n, eo);
      else passed++;
      total++;
      if (n_out_valid !== 1'b1 || n_acc_out !== 8'(ns) || n_beat_cnt !== 4'(n) || n_ovf !== no)
        $display("FAIL rand_narrow got v=%0b acc=%0d cnt=%0d ovf=%0b expected v=1 acc=%0d cnt=%0d ovf=%0b", n_out_valid, $signed(n_acc_out), n_beat_cnt, n_ovf, ns, n, no);
      else passed++;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL rand_drop out_valid=%0b expected 0", out_valid);
      else passed++;
    end
  endtask
  task automatic test_max_beats;
    int es;
    bit eo;
    n = 8;
    for (int i = 0; i < 8; i++) ps[i] = -49;
    drive_burst(1'b0);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 16'hFE78 || beat_cnt !== 4'd8 || ovf !== 1'b0)
      $display("FAIL max_beats got v=%0b acc=%0d cnt=%0d ovf=%0b expected v=1 acc=-392 cnt=8 ovf=0", out_valid, $signed(acc_out), beat_cnt, ovf);
    else passed++;
    @(negedge clk);
    fill_random(8);
    drive_burst(1'b1);
    model(16, es, eo);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 16'(es) || beat_cnt !== 4'd8)
      $display("FAIL coincident got v=%0b acc=%0d cnt=%0d expected v=1 acc=%0d cnt=8", out_valid, $signed(acc_out), beat_cnt, es);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL coincident_single got v=%0b rdy=%0b expected v=0 rdy=1", out_valid, in_ready);
    else passed++;
  endtask
  task automatic test_overflow;
    int ns;
    bit no;
    n = 2; ps[0] = 100; ps[1] = 100;
    drive_burst(1'b1);
`ifdef BOOTH_MAC_SAT_EN
    total++;
    if (n_acc_out !== 8'd127 || n_ovf !== 1'b1)
      $display("FAIL ovf_narrow got acc=%0d ovf=%0b expected acc=127 ovf=1", $signed(n_acc_out), n_ovf);
    else passed++;
`else
    total++;
    if (n_acc_out !== 8'hC8 || n_ovf !== 1'b1)
      $display("FAIL ovf_narrow got acc=%0d ovf=%0b expected acc=-56 ovf=1", $signed(n_acc_out), n_ovf);
    else passed++;
`endif
    total++;
    if (acc_out !== 16'd200 || ovf !== 1'b0)
      $display("FAIL ovf_wide got acc=%0d ovf=%0b expected acc=200 ovf=0", $signed(acc_out), ovf);
    else passed++;
    @(negedge clk);
    n = 3; ps[0] = 100; ps[1] = 100; ps[2] = -100;
    drive_burst(1'b1);
    model(8, ns, no);
    total++;
    if (n_acc_out !== 8'(ns) || n_ovf !== no || n_beat_cnt !== 4'd3)
      $display("FAIL ovf_sticky got acc=%0d ovf=%0b cnt=%0d expected acc=%0d ovf=%0b cnt=3", $signed(n_acc_out), n_ovf, n_beat_cnt, ns, no);
    else passed++;
    @(negedge clk);
  endtask
  task automatic test_backpressure;
    out_ready = 1'b0;
    n = 2; ps[0] = 5; ps[1] = 9;
    drive_burst(1'b1);
    in_valid = 1'b1; prod = 8'd33; in_last = 1'b1;
    repeat (5) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== 16'd14 || beat_cnt !== 4'd2)
        $display("FAIL hold got rdy=%0b v=%0b acc=%0d cnt=%0d expected rdy=0 v=1 acc=14 cnt=2", in_ready, out_valid, $signed(acc_out), beat_cnt);
      else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== 16'd14)
      $display("FAIL release got v=%0b rdy=%0b acc=%0d expected v=0 rdy=1 acc=14", out_valid, in_ready, $signed(acc_out));
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 16'd33 || beat_cnt !== 4'd1)
      $display("FAIL held_beat got v=%0b acc=%0d cnt=%0d expected v=1 acc=33 cnt=1", out_valid, $signed(acc_out), beat_cnt);
    else passed++;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    n = 2; ps[0] = 7; ps[1] = 7;
    drive_burst(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, ovf, beat_cnt, acc_out} !== {1'b1, 1'b0, 1'b0, 4'd0, 16'd0})
      $display("FAIL reset_mid got rdy=%0b v=%0b ovf=%0b cnt=%0d acc=%0d expected 1 0 0 0 0", in_ready, out_valid, ovf, beat_cnt, $signed(acc_out));
    else passed++;
    n = 1; ps[0] = 3;
    drive_burst(1'b1);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 16'd3 || beat_cnt !== 4'd1)
      $display("FAIL after_reset got v=%0b acc=%0d cnt=%0d expected v=1 acc=3 cnt=1", out_valid, $signed(acc_out), beat_cnt);
    else passed++;
    @(negedge clk);
    out_ready = 1'b0;
    ps[0] = -5;
    drive_burst(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== 16'd0)
      $display("FAIL reset_hold got v=%0b rdy=%0b acc=%0d expected v=0 rdy=1 acc=0", out_valid, in_ready, $signed(acc_out));
    else passed++;
  endtask
  task automatic test_single;
    n = 1; ps[0] = -8;
    drive_burst(1'b1);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 16'hFFF8 || beat_cnt !== 4'd1 || n_acc_out !== 8'hF8)
      $display("FAIL single got v=%0b acc=%0d nacc=%0d cnt=%0d expected v=1 acc=-8 nacc=-8 cnt=1", out_valid, $signed(acc_out), $signed(n_acc_out), beat_cnt);
    else passed++;
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int es;
    bit eo;
    repeat (4) begin
      fill_random(8);
      drive_burst(1'b0);
      model(16, es, eo);
      total++;
      if (out_valid !== 1'b1 || acc_out !== 16'(es) || beat_cnt !== 4'd8)
        $display("FAIL b2b got v=%0b acc=%0d cnt=%0d expected v=1 acc=%0d cnt=8", out_valid, $signed(acc_out), beat_cnt, es);
      else passed++;
    end
    @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_max_beats;
    test_overflow;
    test_backpressure;
    test_reset_mid;
    test_single;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end
endmodule
